// File: rtl/imem_loader.sv
// Packs a byte stream into 32-bit instruction words and writes them to imem from byte address 0.
// Latency: 4 accepted bytes then one WRITE cycle per word; Done pulses the cycle after the last write.
// Backpressure: ByteReady is high only in COLLECT and is forced low combinationally while Abort is high.
// Build option: define IMEM_LOADER_CHECKSUM_EN to add a running 32-bit Checksum of written words.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic                  Abort,
    input  logic [ADDR_WIDTH:0]   WordCount,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  MemWrEn,
    output logic [31:0]           MemAddr,
    output logic [31:0]           MemWrData,
    output logic                  Busy,
    output logic                  Done,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [31:0]           Checksum,
`endif
    output logic                  Error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Largest legal WordCount: the whole memory.
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_WORD  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [1:0]            byte_cnt;
    logic [1:0]            lane;
    logic [31:0]           asm_word;
    logic [31:0]           asm_next;
    logic                  byte_xfer;
    logic                  last_word;

    // Abort blocks the handshake in the same cycle so an aborted byte is never consumed.
    assign ByteReady = (state == COLLECT) && !Abort;
    assign byte_xfer = ByteReady && ByteValid;
    // An abort landing on the WRITE cycle suppresses the strobe.
    assign MemWrEn   = (state == WRITE) && !Abort;
    assign Busy      = (state == COLLECT) || (state == WRITE);
    assign Done      = (state == DONE);
    // Word index never exceeds count-1, so it cannot wrap even for a full-memory load.
    assign last_word = ({1'b0, word_idx} == (word_cnt - ONE_WORD));

    // Drop the incoming byte into its lane of the word being assembled.
    always_comb begin
        lane     = BIG_ENDIAN ? (2'd3 - byte_cnt) : byte_cnt;
        asm_next = asm_word;
        asm_next[{lane, 3'b000} +: 8] = ByteIn;
    end

    // Loader FSM together with its datapath and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            word_idx  <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            asm_word  <= '0;
            MemAddr   <= '0;
            MemWrData <= '0;
            Error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            Checksum  <= '0;
`endif
        end else begin
            Error <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (WordCount == '0) begin
                            state <= DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            Checksum <= '0;
`endif
                        end else if (WordCount > MAX_WORDS) begin
                            Error <= 1'b1;
                        end else begin
                            word_cnt <= WordCount;
                            word_idx <= '0;
                            byte_cnt <= '0;
                            asm_word <= '0;
                            state    <= COLLECT;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            Checksum <= '0;
`endif
                        end
                    end
                end
                COLLECT: begin
                    if (Abort) begin
                        state <= IDLE;
                    end else if (byte_xfer) begin
                        asm_word <= asm_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            MemWrData <= asm_next;
                            MemAddr   <= {{(30 - ADDR_WIDTH){1'b0}}, word_idx, 2'b00};
                            state     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (Abort) begin
                        state <= IDLE;
                    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        Checksum <= Checksum + MemWrData;
`endif
                        if (last_word) begin
                            state <= DONE;
                        end else begin
                            word_idx <= word_idx + ADDR_WIDTH'(1);
                            byte_cnt <= '0;
                            state    <= COLLECT;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
